sigmoid_divider: RTL and testbench

SIGMOID_DIVIDER -- requirements
Module: sigmoid_divider

---
 rtl/nn_fixed_pkg.sv | 16 +
 rtl/div_step.sv | 19 +
 rtl/sigmoid_divider.sv | 101 ++++++++++
 tb/tb_sigmoid_divider.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/nn_fixed_pkg.sv
// Shared Q16.16 fixed-point constants and divider FSM states for the sigmoid pipeline.
// Used by the Denominator stage and sigmoid_divider.
package nn_fixed_pkg;
  localparam int          WIDTH     = 32;
  localparam int          FRAC_BITS = 16;
  localparam logic [31:0] ONE       = 32'h0001_0000;
  localparam logic [31:0] SAT_MAX   = 32'h7FFF_FFFF;
  localparam int          DIV_ITERS = 32;
  localparam int          CNT_W     = $clog2(DIV_ITERS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } div_state_t;
endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the remainder left, compare/subtract the divisor.
// Purely combinational; no backpressure.
module div_step
  import nn_fixed_pkg::*;
(
  input  logic [WIDTH:0]   i_rem,
  input  logic [WIDTH-2:0] i_den,
  output logic [WIDTH:0]   o_rem,
  output logic             o_qbit
);
  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_den;

  assign w_shift = {i_rem[WIDTH-1:0], 1'b0};
  assign w_den   = {2'b00, i_den};
  // A bit shifted out of the top already means the true remainder exceeds the divisor.
  assign o_qbit  = i_rem[WIDTH] | (w_shift >= w_den);
  assign o_rem   = o_qbit ? (w_shift - w_den) : w_shift;
endmodule

// File: rtl/sigmoid_divider.sv
// Computes sigmoid = 2^32 / denom[30:0] (Q16.16 reciprocal) with saturation flags.
// Fixed 33-cycle start-to-startout latency; start is dropped while busy.
module sigmoid_divider
  import nn_fixed_pkg::*;
(
  input  logic             CLOCK,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] denom,
  output logic             startout,
  output logic [WIDTH-1:0] sigmoid,
  output logic             ovf,
  output logic             busy
);
  div_state_t       r_state;
  div_state_t       w_state_nxt;
  logic [WIDTH-2:0] r_den;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [CNT_W-1:0] r_cnt;
  logic             r_neg;
  logic             r_small;
  logic             r_startout;
  logic [WIDTH-1:0] r_sigmoid;
  logic             r_ovf;
  logic [WIDTH:0]   w_rem;
  logic             w_qbit;

  div_step u_div_step (
    .i_rem  (r_rem),
    .i_den  (r_den),
    .o_rem  (w_rem),
    .o_qbit (w_qbit)
  );

  always_ff @(posedge CLOCK) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = DIV;
      DIV:     if (r_cnt == CNT_W'(1)) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    if (r_state != IDLE) busy = 1'b1;
  end

  always_ff @(posedge CLOCK) begin
    if (!reset) begin
      r_den      <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_cnt      <= '0;
      r_neg      <= 1'b0;
      r_small    <= 1'b0;
      r_startout <= 1'b0;
      r_sigmoid  <= '0;
      r_ovf      <= 1'b0;
    end else begin
      r_startout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_den   <= denom[WIDTH-2:0];
            r_rem   <= (WIDTH+1)'(1);
            r_quo   <= '0;
            r_cnt   <= CNT_W'(DIV_ITERS);
            // Special cases are latched now; the division still runs its full schedule.
            r_neg   <= denom[WIDTH-1];
            r_small <= (denom <= WIDTH'(2));
          end
        end
        DIV: begin
          r_rem <= w_rem;
          r_quo <= {r_quo[WIDTH-2:0], w_qbit};
          r_cnt <= r_cnt - CNT_W'(1);
        end
        DONE: begin
          r_startout <= 1'b1;
          r_ovf      <= r_neg | r_small;
          if (r_neg)        r_sigmoid <= '0;
          else if (r_small) r_sigmoid <= SAT_MAX;
          else              r_sigmoid <= r_quo;
        end
        default: ;
      endcase
    end
  end

  assign startout = r_startout;
  assign sigmoid  = r_sigmoid;
  assign ovf      = r_ovf;
endmodule

// File: tb/tb_sigmoid_divider.sv
// Bench for sigmoid_divider: vector table, random inputs against a reciprocal model,
// plus hand-written start-while-busy and reset-abort sequences.
module tb_sigmoid_divider;
  logic        CLOCK;
  logic        reset;
  logic        start;
  logic [31:0] denom;
  logic        startout;
  logic [31:0] sigmoid;
  logic        ovf;
  logic        busy;

  int n_pass  = 0;
  int n_total = 0;

  sigmoid_divider dut (
    .CLOCK    (CLOCK),
    .reset    (reset),
    .start    (start),
    .denom    (denom),
    .startout (startout),
    .sigmoid  (sigmoid),
    .ovf      (ovf),
    .busy     (busy)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  typedef struct {
    logic [31:0] d;
    logic [31:0] exp_sig;
    logic        exp_ovf;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reciprocal model: 2^32 / magnitude, with the saturation rules applied first.
  function automatic void model(input logic [31:0] d, output logic [31:0] s, output logic o);
    logic [63:0] q;
    if (d[31]) begin
      s = 32'h0; o = 1'b1;
    end else if (d <= 32'd2) begin
      s = 32'h7FFF_FFFF; o = 1'b1;
    end else begin
      q = 64'h1_0000_0000 / {33'd0, d[30:0]};
      s = q[31:0]; o = 1'b0;
    end
  endfunction

  // Pulse start with d, then watch up to 100 cycles for startout.
  task automatic run_one(input logic [31:0] d, output logic [31:0] sig, output logic ov,
                         output int lat, output int busy_cnt, output logic so_next);
    int k;
    lat = -1; busy_cnt = 0; sig = '0; ov = 1'b0; so_next = 1'b1;
    @(negedge CLOCK);
    denom = d; start = 1'b1;
    @(negedge CLOCK);
    start = 1'b0;
    k = 0;
    while (k < 100) begin
      if (busy) busy_cnt++;
      if (startout) begin
        lat = k; sig = sigmoid; ov = ovf;
        break;
      end
      @(negedge CLOCK);
      k++;
    end
    @(negedge CLOCK);
    so_next = startout;
  endtask

  vec_t        vecs[10];
  logic [31:0] s, es;
  logic        o, eo, sn;
  int          lat, bc, so_cnt;
  logic [31:0] rd;

  initial begin
    reset = 1'b0; start = 1'b0; denom = '0;
    repeat (3) @(negedge CLOCK);
    chk("reset_startout", {63'd0, startout}, 64'd0);
    chk("reset_sigmoid", {32'd0, sigmoid}, 64'd0);
    chk("reset_ovf", {63'd0, ovf}, 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);

    // start coincident with active reset must be ignored
    start = 1'b1; denom = 32'h0002_0000;
    @(negedge CLOCK);
    start = 1'b0;
    reset = 1'b1;
    @(negedge CLOCK);
    chk("start_in_reset_busy", {63'd0, busy}, 64'd0);

    vecs[0] = '{32'h0002_0000, 32'h0000_8000, 1'b0};
    vecs[1] = '{32'h0001_0000, 32'h0001_0000, 1'b0};
    vecs[2] = '{32'h0001_8000, 32'h0000_AAAA, 1'b0};
    vecs[3] = '{32'h7FFF_FFFF, 32'h0000_0002, 1'b0};
    vecs[4] = '{32'h0000_0002, 32'h7FFF_FFFF, 1'b1};
    vecs[5] = '{32'h0000_0000, 32'h7FFF_FFFF, 1'b1};
    vecs[6] = '{32'h8000_0000, 32'h0000_0000, 1'b1};
    vecs[7] = '{32'h0004_0000, 32'h0000_4000, 1'b0};
    vecs[8] = '{32'h0000_0003, 32'h5555_5555, 1'b0};
    vecs[9] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1};

    for (int i = 0; i < 10; i++) begin
      run_one(vecs[i].d, s, o, lat, bc, sn);
      chk($sformatf("vec%0d_sigmoid", i), {32'd0, s}, {32'd0, vecs[i].exp_sig});
      chk($sformatf("vec%0d_ovf", i), {63'd0, o}, {63'd0, vecs[i].exp_ovf});
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd33);
      chk($sformatf("vec%0d_startout_once", i), {63'd0, sn}, 64'd0);
      if (i == 0) chk("busy_cycles", 64'(bc), 64'd33);
    end

    for (int i = 0; i < 24; i++) begin
      case (i % 4)
        0: rd = $urandom_range(0, 8);
        1: rd = {1'b1, 31'($urandom)};
        default: rd = {1'b0, 31'($urandom)};
      endcase
      model(rd, es, eo);
      run_one(rd, s, o, lat, bc, sn);
      chk($sformatf("rand%0d_sigmoid d=0x%0h", i, rd), {32'd0, s}, {32'd0, es});
      chk($sformatf("rand%0d_ovf", i), {63'd0, o}, {63'd0, eo});
      chk($sformatf("rand%0d_latency", i), 64'(lat), 64'd33);
    end

    // start pulses while busy are dropped; result comes from the first denom
    @(negedge CLOCK);
    denom = 32'h0002_0000; start = 1'b1;
    @(negedge CLOCK);
    start = 1'b0;
    so_cnt = 0; lat = -1; s = '0;
    for (int k = 0; k < 80; k++) begin
      if (k == 4 || k == 19) begin
        denom = 32'h0004_0000; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (startout) begin
        so_cnt++;
        if (lat < 0) begin lat = k; s = sigmoid; end
      end
      @(negedge CLOCK);
    end
    start = 1'b0;
    chk("busy_start_count", 64'(so_cnt), 64'd1);
    chk("busy_start_latency", 64'(lat), 64'd33);
    chk("busy_start_sigmoid", {32'd0, s}, 64'h8000);

    // reset mid-division aborts with no startout
    @(negedge CLOCK);
    denom = 32'h0002_0000; start = 1'b1;
    @(negedge CLOCK);
    start = 1'b0;
    so_cnt = 0;
    for (int k = 0; k < 60; k++) begin
      reset = (k == 9) ? 1'b0 : 1'b1;
      if (startout) so_cnt++;
      @(negedge CLOCK);
    end
    chk("abort_no_startout", 64'(so_cnt), 64'd0);
    chk("abort_sigmoid", {32'd0, sigmoid}, 64'd0);
    chk("abort_ovf", {63'd0, ovf}, 64'd0);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    run_one(32'h0004_0000, s, o, lat, bc, sn);
    chk("after_abort_sigmoid", {32'd0, s}, 64'h4000);
    chk("after_abort_latency", 64'(lat), 64'd33);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
